// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO capture stage of the iterative multiplier:
// FSM state encodings, HI/LO select codes and default sizing constants.
package mult_hilo_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2
  } hilo_state_e;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_TIMEOUT = 48;
  localparam int DEFAULT_CNT_W   = 6;

endpackage

// File: rtl/mult_hilo_unit_watchdog.sv
// Cycle counter that measures how long a multiply has been in flight and
// flags expiry once the count reaches TIMEOUT.
module mult_watchdog
  import mult_hilo_unit_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // clear wins over enable so a fresh operation always starts counting from zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TIMEOUT_CNT);

endmodule

// File: rtl/mult_hilo_unit.sv
// HI/LO register stage behind the iterative multiplier: captures the product,
// serves mfhi/mflo/mthi/mtlo, stalls reads while busy and flags hangs/overruns.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*DATA_W-1:0]   mul_r,
  input  logic                  mul_valid,
  input  logic                  rd_req,
  input  logic                  rd_sel,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  err_overrun
);

  hilo_state_e       state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;
  logic              wd_clear;
  logic              wd_expired;

  mult_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (busy),
    .expired (wd_expired)
  );

  assign busy    = (state_q != ST_IDLE);
  assign stall   = rd_req & busy;
  assign rd_data = (rd_sel == HILO_SEL_HI) ? hi_q : lo_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

  // ARM only moves on once validity is low so a level left over from the
  // previous product can never be mistaken for the new one.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q | (start & busy);
    wd_clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          if (rd_sel == HILO_SEL_HI) begin
            hi_d = wr_data;
          end else begin
            lo_d = wr_data;
          end
        end
        if (start) begin
          state_d  = ST_ARM;
          wd_clear = 1'b1;
        end
      end
      ST_ARM: begin
        if (wd_expired) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
        end else if (!mul_valid) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mul_valid) begin
          hi_d    = mul_r[2*DATA_W-1:DATA_W];
          lo_d    = mul_r[DATA_W-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: expected products are queued when a
// capture is set up and compared against HI/LO once done is seen.
module tb_mult_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mul_r;
  logic        mul_valid;
  logic        rd_req;
  logic        rd_sel;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic        err_timeout;
  logic        err_overrun;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  mult_hilo_unit #(
    .DATA_W  (16),
    .TIMEOUT (48),
    .CNT_W   (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mul_r       (mul_r),
    .mul_valid   (mul_valid),
    .rd_req      (rd_req),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic mv, input logic [31:0] r,
                               input logic rq, input logic sel, input logic we,
                               input logic [15:0] wd);
    start     = st;
    mul_valid = mv;
    mul_r     = r;
    rd_req    = rq;
    rd_sel    = sel;
    wr_en     = we;
    wr_data   = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readHiLo(output logic [15:0] hi, output logic [15:0] lo);
    rd_sel = 1'b1;
    #1;
    hi = rd_data;
    rd_sel = 1'b0;
    #1;
    lo = rd_data;
  endtask

  // Waits a bounded number of cycles for done, then checks HI/LO against the queue head.
  task automatic waitDoneAndCompare(input string tag, input int budget);
    logic        seen;
    logic [31:0] exp;
    logic [15:0] hi, lo;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        exp = sb.pop_front();
        readHiLo(hi, lo);
        checkOutput({tag, "_hi"}, {16'd0, hi}, {16'd0, exp[31:16]});
        checkOutput({tag, "_lo"}, {16'd0, lo}, {16'd0, exp[15:0]});
      end
    end
  endtask

  initial begin
    logic [15:0] hi, lo;
    logic        left;

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b1;
    #3;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_errs", {30'd0, err_timeout, err_overrun}, 32'd0);
    readHiLo(hi, lo);
    checkOutput("rst_hilo", {hi, lo}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // normal multiply
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    start = 1'b0;
    checkOutput("norm_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    checkOutput("norm_no_done", {31'd0, done}, 32'd0);
    mul_valid = 1'b1;
    mul_r     = 32'h1234_5678;
    sb.push_back(32'h1234_5678);
    waitDoneAndCompare("norm", 5);
    tick();
    checkOutput("norm_done_pulse", {31'd0, done}, 32'd0);

    // stale validity: mul_valid still high from previous op
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("stale_busy", {31'd0, busy}, 32'd1);
    checkOutput("stale_no_done", {31'd0, done}, 32'd0);
    mul_valid = 1'b0;
    tick();
    mul_valid = 1'b1;
    mul_r     = 32'h0000_0006;
    sb.push_back(32'h0000_0006);
    waitDoneAndCompare("stale", 5);

    // stall through the whole operation including the capture cycle
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    #1;
    checkOutput("stall_idle", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_busy", {31'd0, stall}, 32'd1);
      tick();
    end
    mul_valid = 1'b1;
    mul_r     = 32'hCAFE_0042;
    sb.push_back(32'hCAFE_0042);
    #1;
    checkOutput("stall_capture_cycle", {31'd0, stall}, 32'd1);
    tick();
    checkOutput("stall_released", {31'd0, stall}, 32'd0);
    checkOutput("stall_rd_data", {16'd0, rd_data}, 32'h0000_0042);
    if (sb.size() > 0) begin
      lo = sb[0][15:0];
      checkOutput("stall_sb_lo", {16'd0, rd_data}, {16'd0, lo});
      void'(sb.pop_front());
    end
    rd_req = 1'b0;

    // overrun and write while busy, then idle write
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    checkOutput("ovr_pre", {31'd0, err_overrun}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("ovr_flag", {31'd0, err_overrun}, 32'd1);
    checkOutput("ovr_busy", {31'd0, busy}, 32'd1);
    mul_valid = 1'b1;
    mul_r     = 32'h1111_2222;
    sb.push_back(32'h1111_2222);
    waitDoneAndCompare("ovr", 5);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 16'hABCD);
    tick();
    wr_en = 1'b0;
    readHiLo(hi, lo);
    checkOutput("wr_hi", {16'd0, hi}, 32'h0000_ABCD);
    checkOutput("wr_lo_kept", {16'd0, lo}, 32'h0000_2222);

    // timeout with mul_valid stuck low
    applyStimulus(1'b1, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checkOutput("to_busy_early", {31'd0, busy}, 32'd1);
    checkOutput("to_no_err_early", {31'd0, err_timeout}, 32'd0);
    left = 1'b0;
    for (int i = 0; i < 20 && !left; i++) begin
      tick();
      checkOutput("to_no_done", {31'd0, done}, 32'd0);
      if (!busy) left = 1'b1;
    end
    checkOutput("to_left_busy", {31'd0, left}, 32'd1);
    checkOutput("to_err", {31'd0, err_timeout}, 32'd1);
    checkOutput("to_ovr_sticky", {31'd0, err_overrun}, 32'd1);
    readHiLo(hi, lo);
    checkOutput("to_hilo_kept", {hi, lo}, 32'hABCD_2222);

    // asynchronous reset in the middle of an operation
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    start = 1'b0;
    tick();
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("mid_rst_errs", {30'd0, err_timeout, err_overrun}, 32'd0);
    readHiLo(hi, lo);
    checkOutput("mid_rst_hilo", {hi, lo}, 32'd0);
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    tick();
    checkOutput("post_rst_done", {31'd0, done}, 32'd0);
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
